// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative RV32M multiply/divide unit.
//   - state_e       : FSM state encoding (2 bits)
//   - FUNCT3_*      : funct3 op-select values of the M extension
//   - M_FUNCT7      : funct7 value identifying an M-extension R-type op
//   - ITER_LAST     : counter value of the final iteration
//   - helper functions for operand signedness and conditional negation
// ---------------------------------------------------------------------------
package muldiv_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  localparam logic [6:0] M_FUNCT7  = 7'b0000001;
  localparam logic [5:0] ITER_LAST = 6'd31;

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
  function automatic logic a_is_signed(input logic [2:0] funct3);
    return (funct3 == FUNCT3_MULH) || (funct3 == FUNCT3_MULHSU) ||
           (funct3 == FUNCT3_DIV)  || (funct3 == FUNCT3_REM);
  endfunction

  // rs2 is treated as signed only by MULH, DIV and REM.
  function automatic logic b_is_signed(input logic [2:0] funct3);
    return (funct3 == FUNCT3_MULH) || (funct3 == FUNCT3_DIV) ||
           (funct3 == FUNCT3_REM);
  endfunction

  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] val,
                                               input logic             neg);
    return neg ? (~val + 1'b1) : val;
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// ---------------------------------------------------------------------------
// muldiv_div_step
// One combinational iteration of restoring division on unsigned magnitudes.
// Ports:
//   rem_i          : partial remainder from the previous iteration (< divisor)
//   dividend_bit_i : next dividend bit, taken MSB-first
//   divisor_i      : divisor magnitude
//   rem_o          : partial remainder after this iteration
//   q_bit_o        : quotient bit produced by this iteration
// ---------------------------------------------------------------------------
module muldiv_div_step
  import muldiv_pkg::*;
(
  input  logic [DATA_W-1:0] rem_i,
  input  logic              dividend_bit_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic              q_bit_o
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // The shifted remainder needs one extra bit, since rem_i < divisor can
  // still yield a value up to 2*divisor-1. The top bit of the difference
  // is the borrow: set means the trial subtraction must be undone.
  always_comb begin
    shifted = {rem_i, dividend_bit_i};
    diff    = shifted - {1'b0, divisor_i};
    q_bit_o = ~diff[DATA_W];
    rem_o   = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit
// Iterative RV32M multiply/divide unit sitting in EX behind the ID/EX
// register. Multiplies by 32-step shift-add, divides by 32-step restoring
// division, stalling the pipeline while it works.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   start_i    : qualified M-extension op present in EX
//   funct3_i   : operation select
//   op_a_i     : rs1 operand (post-forwarding)
//   op_b_i     : rs2 operand (post-forwarding)
//   flush_i    : kill the EX instruction, abandon any operation in flight
//   busy_o     : stall request to the hazard unit
//   done_o     : one-cycle pulse, result_o valid
//   result_o   : registered 32-bit result
// ---------------------------------------------------------------------------
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = DATA_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  state_e            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;

  // Operand preparation, only meaningful while in IDLE.
  logic            a_sgn, b_sgn;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            is_div, is_rem;
  logic            div_zero, div_ovf;

  // Datapath step results.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN-1:0]   div_rem;
  logic              div_qbit;
  logic [XLEN-1:0]   div_quot_next;
  logic [XLEN-1:0]   div_res;

  muldiv_div_step u_div_step (
    .rem_i          (acc_q[XLEN-1:0]),
    .dividend_bit_i (a_q[XLEN-1]),
    .divisor_i      (b_q),
    .rem_o          (div_rem),
    .q_bit_o        (div_qbit)
  );

  // Magnitudes and special-case detection from the raw operands.
  // The most negative value negates to itself, which is still the correct
  // unsigned magnitude 2^31.
  always_comb begin
    a_sgn    = a_is_signed(funct3_i) & op_a_i[XLEN-1];
    b_sgn    = b_is_signed(funct3_i) & op_b_i[XLEN-1];
    a_mag    = neg_if(op_a_i, a_sgn);
    b_mag    = neg_if(op_b_i, b_sgn);
    is_div   = funct3_i[2];
    is_rem   = funct3_i[1];
    div_zero = is_div & (op_b_i == '0);
    div_ovf  = ((funct3_i == FUNCT3_DIV) || (funct3_i == FUNCT3_REM)) &
               (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) & (op_b_i == '1);
  end

  // Shift-add multiply: add the multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole accumulator right.
  // After 32 steps the accumulator holds the 64-bit product magnitude.
  always_comb begin
    mul_sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (b_q[0] ? {1'b0, a_q} : '0);
    mul_acc_next = {mul_sum, acc_q[XLEN-1:1]};
    prod         = neg_q ? (~mul_acc_next + 1'b1) : mul_acc_next;
    mul_res      = (f3_q == FUNCT3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // Divide: the dividend register shifts out MSB-first and collects the
  // quotient bits in from the LSB. neg_q already carries the right sign for
  // the selected output (quotient or remainder).
  always_comb begin
    div_quot_next = {a_q[XLEN-2:0], div_qbit};
    div_res       = f3_q[1] ? neg_if(div_rem, neg_q) : neg_if(div_quot_next, neg_q);
  end

  // Next-state logic. The result is captured on the edge into DONE so the
  // output is purely registered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          f3_d  = funct3_i;
          a_d   = a_mag;
          b_d   = b_mag;
          neg_d = (is_div & is_rem) ? a_sgn : (a_sgn ^ b_sgn);
          acc_d = '0;
          cnt_d = '0;
          if (div_zero) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = is_rem ? op_a_i : '1;
          end else if (div_ovf) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = is_rem ? '0 : op_a_i;
          end else begin
            state_d = is_div ? ST_DIV : ST_MUL;
          end
        end
      end
      ST_MUL: begin
        acc_d = mul_acc_next;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == ITER_LAST) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          result_d = mul_res;
        end
      end
      ST_DIV: begin
        acc_d = {{XLEN{1'b0}}, div_rem};
        a_d   = div_quot_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == ITER_LAST) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          result_d = div_res;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A flush overrides everything, including a start seen in IDLE.
    if (flush_i) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      f3_q     <= FUNCT3_MUL;
      neg_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // busy must rise in the cycle the op enters EX, so it looks at start_i
  // directly. It stays low in DONE so the pipeline advances on that edge.
  // A flush landing in the DONE cycle kills the instruction, so its done
  // pulse is suppressed as well.
  always_comb begin
    busy_o   = ~rst & ((start_i & (state_q != ST_DONE) & ~flush_i) |
                       (state_q == ST_MUL) | (state_q == ST_DIV));
    done_o   = done_q & ~flush_i;
    result_o = result_q;
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv_unit
// Directed bench for ex_muldiv_unit with hand-computed expected values.
// Inputs change 1 ns after a rising edge; outputs are sampled on the
// falling edge. Cycle 0 of an op is the cycle in which start_i is first
// seen in IDLE.
// ---------------------------------------------------------------------------
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int num_checks = 0;
  int num_errors = 0;
  int cyc_cnt    = 0;

  int done_at_1;
  int done_at_2;
  int dummy_at;
  bit seen_done;
  bit seen_busy;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic apply_stimulus(input logic start, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic flush);
    start_i  = start;
    funct3_i = f3;
    op_a_i   = a;
    op_b_i   = b;
    flush_i  = flush;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    num_checks++;
    assert (observed === expected)
    else begin
      num_errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Issue one op at the current cycle (caller is 1 ns past a rising edge),
  // keep start_i high as a stalled pipeline would, scramble the operand
  // inputs mid-operation, and check latency, busy profile and result.
  // Returns 1 ns past the edge that ends the DONE cycle, start_i low.
  task automatic run_op(input string tag, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat,
                        output int done_at);
    int          lat;
    bit          busy_ok;
    logic        busy_at_done;
    logic [31:0] res;
    lat          = -1;
    busy_ok      = 1'b1;
    busy_at_done = 1'bx;
    res          = 'x;
    done_at      = -1;
    apply_stimulus(1'b1, f3, a, b, 1'b0);
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (done_o === 1'b1) begin
        lat          = c;
        res          = result_o;
        busy_at_done = busy_o;
        done_at      = cyc_cnt;
        break;
      end
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      if (c == 4) begin
        op_a_i = $urandom;
        op_b_i = $urandom;
      end
    end
    if (lat >= 0) begin
      @(posedge clk);
      #1;
    end
    start_i = 1'b0;
    check_output({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_output({tag, "_result"}, res, exp_res);
    check_output({tag, "_busy_at_done"}, {31'b0, busy_at_done}, 32'd0);
    check_output({tag, "_busy_before_done"}, {31'b0, busy_ok}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    apply_stimulus(1'b1, FUNCT3_MUL, 32'd7, 32'd3, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_busy", {31'b0, busy_o}, 32'd0);
    check_output("reset_done", {31'b0, done_o}, 32'd0);
    check_output("reset_result", result_o, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply_stimulus(1'b0, FUNCT3_MUL, 32'd0, 32'd0, 1'b0);

    // Flush and start together in IDLE: nothing may start.
    @(posedge clk);
    #1;
    apply_stimulus(1'b1, FUNCT3_MUL, 32'd7, 32'd3, 1'b1);
    @(negedge clk);
    check_output("flush_start_busy", {31'b0, busy_o}, 32'd0);
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, FUNCT3_MUL, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    check_output("flush_start_not_running", {31'b0, busy_o}, 32'd0);
    check_output("flush_start_no_done", {31'b0, done_o}, 32'd0);
    @(posedge clk);
    #1;

    // Multiplies.
    run_op("mul_7_m3", FUNCT3_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, dummy_at);
    @(negedge clk);
    check_output("done_single_pulse", {31'b0, done_o}, 32'd0);
    @(posedge clk);
    #1;
    run_op("mulhu_ones", FUNCT3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, dummy_at);
    run_op("mulh_ones", FUNCT3_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, dummy_at);
    run_op("mulhsu_ones", FUNCT3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, dummy_at);
    run_op("mulhsu_m2_3", FUNCT3_MULHSU, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 33, dummy_at);
    run_op("mulh_big", FUNCT3_MULH, 32'h40000000, 32'h00000010, 32'h00000004, 33, dummy_at);

    // Divides.
    run_op("div_m7_2", FUNCT3_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, dummy_at);
    run_op("rem_m7_2", FUNCT3_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, dummy_at);
    run_op("div_7_m2", FUNCT3_DIV, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33, dummy_at);
    run_op("rem_7_m2", FUNCT3_REM, 32'd7, 32'hFFFFFFFE, 32'h00000001, 33, dummy_at);
    run_op("divu_100_7", FUNCT3_DIVU, 32'd100, 32'd7, 32'd14, 33, dummy_at);
    run_op("remu_100_7", FUNCT3_REMU, 32'd100, 32'd7, 32'd2, 33, dummy_at);

    // Special cases finish in one cycle.
    run_op("divu_5_0", FUNCT3_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1, dummy_at);
    run_op("rem_5_0", FUNCT3_REM, 32'd5, 32'd0, 32'd5, 1, dummy_at);
    run_op("div_ovf", FUNCT3_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, dummy_at);
    run_op("rem_ovf", FUNCT3_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, dummy_at);

    // Reset pulsed at cycle 10 of a DIV.
    apply_stimulus(1'b1, FUNCT3_DIV, 32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst     = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    check_output("rst_abort_busy", {31'b0, busy_o}, 32'd0);
    check_output("rst_abort_result", result_o, 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    seen_done = 1'b0;
    seen_busy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o !== 1'b0) seen_done = 1'b1;
      if (busy_o !== 1'b0) seen_busy = 1'b1;
    end
    check_output("rst_abort_no_done", {31'b0, seen_done}, 32'd0);
    check_output("rst_abort_idle", {31'b0, seen_busy}, 32'd0);
    @(posedge clk);
    #1;

    // Flush at cycle 20 of a MUL.
    apply_stimulus(1'b1, FUNCT3_MUL, 32'd7, 32'd3, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(negedge clk);
    check_output("flush_abort_no_done_now", {31'b0, done_o}, 32'd0);
    @(posedge clk);
    #1;
    apply_stimulus(1'b0, FUNCT3_MUL, 32'd0, 32'd0, 1'b0);
    seen_done = 1'b0;
    seen_busy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o !== 1'b0) seen_done = 1'b1;
      if (busy_o !== 1'b0) seen_busy = 1'b1;
    end
    check_output("flush_abort_no_done", {31'b0, seen_done}, 32'd0);
    check_output("flush_abort_idle", {31'b0, seen_busy}, 32'd0);
    @(posedge clk);
    #1;
    run_op("mulhu_3_5", FUNCT3_MULHU, 32'd3, 32'd5, 32'd0, 33, dummy_at);

    // Back-to-back ops.
    run_op("b2b_mul_2_3", FUNCT3_MUL, 32'd2, 32'd3, 32'd6, 33, done_at_1);
    run_op("b2b_divu_9_2", FUNCT3_DIVU, 32'd9, 32'd2, 32'd4, 33, done_at_2);
    check_output("b2b_done_spacing", 32'(done_at_2 - done_at_1), 32'd34);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the operands and the funct3/funct7 fields that the ID/EX register forwards. For every M-extension instruction it runs a 32-iteration shift-add or restoring-divide sequence. While the sequence runs, it holds the pipeline via a stall output, then presents the 32-bit result to the EX result mux for one cycle.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start_i  in  1  M-extension op present in EX: ALUOp = R-type and funct7 = 7'b0000001, qualified by ID/EX not flushed.
- funct3_i  in  3  operation select.
- op_a_i  in  XLEN  rs1 operand, post-forwarding.
- op_b_i  in  XLEN  rs2 operand, post-forwarding.
- flush_i  in  1  abort the current operation (branch/exception kill of the EX instruction).
- busy_o  out  1  stall request to the hazard unit; freezes PC, IF/ID and ID/EX.
- done_o  out  1  result valid this cycle, one-cycle pulse.
- result_o  out  XLEN  operation result; meaningful only while done_o = 1.

## Operation
- States: IDLE, MUL, DIV, DONE. Encoding is 2 bits.
- IDLE, start_i = 1: latch funct3, |a|, |b| and the result sign. Clear the 64-bit accumulator and the 6-bit counter.
  - Next state is MUL for funct3[2] = 0.
  - Next state is DIV for funct3[2] = 1.
  - Next state is DONE directly on a special case.
- Special cases take the IDLE -> DONE path:
  - Divide by zero: DIV/DIVU -> 32'hFFFFFFFF; REM/REMU -> op_a.
  - Signed overflow, DIV 32'h80000000 / -1: quotient 32'h80000000, remainder 0.
- Signedness:
  - MULH and DIV/REM take both operands signed.
  - MULHSU takes op_a signed and op_b unsigned.
  - MUL, MULHU, DIVU and REMU take both operands unsigned. MUL's low word is sign-agnostic.
- MUL: one partial product per cycle, LSB-first. On counter = 31 the next state is DONE.
  - The product sign is fixed by two's-complement negation of the 64-bit magnitude.
- DIV: restoring division, one quotient bit per cycle, MSB-first. On counter = 31 the next state is DONE.
  - The quotient sign is sign(a) XOR sign(b).
  - The remainder sign is sign(a).
- Result select:
  - MUL -> low 32 bits.
  - MULH, MULHSU, MULHU -> high 32 bits.
  - DIV, DIVU -> quotient.
  - REM, REMU -> remainder.
- DONE: done_o = 1; next state is IDLE unconditionally. Because the pipeline advances on this edge, the same instruction is not restarted.
- Operand inputs are ignored outside IDLE. Their changes mid-operation have no effect.
- flush_i = 1 in any state: next state is IDLE, no done_o pulse, accumulator contents are don't-care.
- flush_i and start_i both high in IDLE: flush wins, no start.

## Timing
- Reset values: state IDLE, counter 0, accumulator 0, done_o 0, result_o 0.
- busy_o = 0 while rst = 1.
- busy_o is combinational: (start_i & state != DONE & !flush_i) | state == MUL | state == DIV.
  - It therefore rises in the same cycle the M-op enters EX.
- Latency for normal ops, with start seen in IDLE at cycle 0:
  - MUL/DIV iterations occupy cycles 1..32.
  - DONE and done_o occur at cycle 33.
  - busy_o is high on cycles 0..32 and low on cycle 33.
- Latency for special cases: DONE at cycle 1; busy_o is high on cycle 0 only.
- Back-to-back M-ops: the DONE -> IDLE edge lets the next op start the following cycle. Throughput is 1 op per 34 cycles.
- Reset asserted mid-operation: all state clears immediately and asynchronously, with no done_o. Normal operation resumes on the first edge after deassertion.
- result_o is registered, so there is no combinational path from op_a_i/op_b_i to result_o.

## Structure
- Shared package muldiv_pkg:
  - state enum.
  - funct3 constants: MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011, DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111.
  - M_FUNCT7 = 7'b0000001.
  - ITER_LAST = 31.
- Sub-module muldiv_div_step: combinational single restoring-divide iteration. It takes the remainder and dividend bit and produces the next remainder and quotient bit. It is instantiated once.
- Multiply step, sign correction, FSM and counter live in the top level.

## Test plan
- MUL 7 × -3 (32'hFFFFFFFD), start at cycle 0 -> busy_o high cycles 0..32; done_o at cycle 33 with result_o = 32'hFFFFFFEB.
- With op_a = op_b = 32'hFFFFFFFF -> MULHU = 32'hFFFFFFFE, MULH = 32'h00000000, MULHSU = 32'hFFFFFFFF.
- DIV -7 / 2 -> 32'hFFFFFFFD; REM -7 / 2 -> 32'hFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- DIVU 5 / 0 -> 32'hFFFFFFFF and REM 5 / 0 -> 5, each with done_o at cycle 1. DIV 32'h80000000 / 32'hFFFFFFFF -> 32'h80000000; REM of the same -> 0.
- Abort cases:
  - rst pulsed at cycle 10 of a DIV -> busy_o 0 and no done_o.
  - flush_i at cycle 20 of a MUL -> IDLE with no done_o.
  - A following MULHU 3 × 5 -> done_o at cycle 33 with result 0.
- Back-to-back MUL 2 × 3 then DIVU 9 / 2 -> results 6 and 4, with done_o pulses 34 cycles apart. Operand inputs toggled mid-operation do not change either result.
